// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder: FSM state encoding and
// the digit-counter width calculation.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_digit_adder_fa_cell.sv
// One-bit full adder; the top chains DIGIT of these into the per-cycle ripple path.
module fa_cell (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic c
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per cycle through a short ripple
// chain, carrying between digits in a register. valid/ready on both sides.
module serial_digit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGIT  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  generate
    if ((DIGIT < 1) || (DIGIT > WIDTH)) begin : g_bad_digit
      $error("serial_digit_adder: DIGIT must lie in 1..WIDTH");
    end
    if ((WIDTH % DIGIT) != 0) begin : g_bad_width
      $error("serial_digit_adder: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  // Handshake: a transfer happens on any rising edge where valid and ready are
  // both high; valid holds its bundle stable until that edge, ready may be
  // raised without waiting for valid.

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             carry_q;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic             last;
  logic             accept;
  logic             release_res;

  assign accept      = in_valid && in_ready_q;
  assign release_res = out_valid_q && out_ready;
  assign last        = (k == CW'(NDIG - 1));

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (k == CW'(d)) begin
        a_dig = a_q[d*DIGIT +: DIGIT];
        b_dig = b_q[d*DIGIT +: DIGIT];
      end
    end
  end

  assign c[0] = carry_q;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_chain
      fa_cell u_fa (
        .sum  (dsum[gi]),
        .cout (c[gi+1]),
        .a    (a_dig[gi]),
        .b    (b_dig[gi]),
        .c    (c[gi])
      );
    end
  endgenerate

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)      next_state = RUN;
      RUN:     if (last)        next_state = DONE;
      DONE:    if (release_res) next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      k           <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= next_state;
      in_ready_q  <= (next_state == IDLE);
      out_valid_q <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            sub_q   <= sub;
            carry_q <= sub | cin;
            k       <= '0;
          end
        end
        RUN: begin
          carry_q <= c[DIGIT];
          for (int d = 0; d < NDIG; d++) begin
            if (k == CW'(d)) begin
              sum_q[d*DIGIT +: DIGIT] <= dsum;
            end
          end
          // The counter stops on the last digit, so it never wraps.
          if (last) begin
            ovf_q <= SIGNED ? (c[DIGIT-1] ^ c[DIGIT]) : (c[DIGIT] ^ sub_q);
          end else begin
            k <= k + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = carry_q;
  assign ovf       = ovf_q;

endmodule
